mul_ctrl: RTL and testbench

//  Sequences the multi-cycle mul unit for the EX stage. Handles MULT/MULTU, MADD(U)/MSUB(U) and MUL.

---
 rtl/mul_ctrl_pkg.sv | 34 +++
 rtl/mul_ctrl_if.sv | 24 ++
 rtl/mul_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mul_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply sequencer: op codes, FSM states, op classification.
package mul_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ACC   = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } mul_state_e;

    localparam logic [2:0] MUL_OP_MULT  = 3'd0;
    localparam logic [2:0] MUL_OP_MULTU = 3'd1;
    localparam logic [2:0] MUL_OP_MADD  = 3'd2;
    localparam logic [2:0] MUL_OP_MADDU = 3'd3;
    localparam logic [2:0] MUL_OP_MSUB  = 3'd4;
    localparam logic [2:0] MUL_OP_MSUBU = 3'd5;
    localparam logic [2:0] MUL_OP_MUL   = 3'd6;
    localparam logic [2:0] MUL_OP_RSVD  = 3'd7;

    function automatic logic op_is_unsigned(input logic [2:0] op);
        return (op == MUL_OP_MULTU) || (op == MUL_OP_MADDU) || (op == MUL_OP_MSUBU);
    endfunction

    function automatic logic op_is_acc(input logic [2:0] op);
        return (op == MUL_OP_MADD) || (op == MUL_OP_MADDU) ||
               (op == MUL_OP_MSUB) || (op == MUL_OP_MSUBU);
    endfunction

    function automatic logic op_is_sub(input logic [2:0] op);
        return (op == MUL_OP_MSUB) || (op == MUL_OP_MSUBU);
    endfunction

endpackage

// File: rtl/mul_ctrl_if.sv
// Link between the multiply sequencer (master) and the multi-cycle mul unit (slave).
interface mul_ctrl_if #(
    parameter int DATA_W = 32
);
    // mul_valid is a one-cycle start pulse carrying mul_a/mul_b/mul_unsigned; the unit has no
    // ready/backpressure and answers each start with exactly one mul_done pulse, with mul_result
    // valid in that same cycle. A started multiply cannot be cancelled.
    logic                mul_valid;
    logic [DATA_W-1:0]   mul_a;
    logic [DATA_W-1:0]   mul_b;
    logic                mul_unsigned;
    logic [2*DATA_W+1:0] mul_result;
    logic                mul_done;

    modport master (
        output mul_valid, mul_a, mul_b, mul_unsigned,
        input  mul_result, mul_done
    );

    modport slave (
        input  mul_valid, mul_a, mul_b, mul_unsigned,
        output mul_result, mul_done
    );
endinterface

// File: rtl/mul_ctrl.sv
// EX-stage multiply sequencer: issues one mul per instruction, stalls the pipe, optionally
// accumulates into HI/LO, and absorbs flushes by draining the in-flight multiply.
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter bit ACC_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_op_valid,
    input  logic [2:0]        ex_op,
    input  logic [DATA_W-1:0] ex_src1,
    input  logic [DATA_W-1:0] ex_src2,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    input  logic              flush,
    output logic              stall_req,
    output logic              hilo_we,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              gpr_valid,
    output logic [DATA_W-1:0] gpr_result,
    mul_ctrl_if.master        mul_if,
    output mul_state_e        dbg_state
);

    mul_state_e          state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   hi_l_q, hi_l_d, lo_l_q, lo_l_d;
    logic [2*DATA_W-1:0] p_q, p_d;
    logic [DATA_W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic                mul_unsigned_q, mul_unsigned_d;
    logic                mul_valid_q, mul_valid_d;
    logic [DATA_W-1:0]   hi_out_q, hi_out_d, lo_out_q, lo_out_d;
    logic [DATA_W-1:0]   gpr_result_q, gpr_result_d;

    logic                issue;
    logic                acc_op;
    logic [2*DATA_W-1:0] acc_base, acc_res;
    logic [1:0]          unused_result_msbs;

    assign issue    = ex_op_valid && !flush && (ex_op != MUL_OP_RSVD);
    assign acc_op   = ACC_EN && op_is_acc(op_q);
    assign acc_base = {hi_l_q, lo_l_q};
    assign acc_res  = op_is_sub(op_q) ? (acc_base - p_q) : (acc_base + p_q);

    // The mul unit reports two extra result bits that this datapath never needs.
    assign unused_result_msbs = mul_if.mul_result[2*DATA_W+1:2*DATA_W];

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        hi_l_d         = hi_l_q;
        lo_l_d         = lo_l_q;
        p_d            = p_q;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        mul_unsigned_d = mul_unsigned_q;
        mul_valid_d    = 1'b0;
        hi_out_d       = hi_out_q;
        lo_out_d       = lo_out_q;
        gpr_result_d   = gpr_result_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    op_d           = ex_op;
                    hi_l_d         = hi_in;
                    lo_l_d         = lo_in;
                    mul_a_d        = ex_src1;
                    mul_b_d        = ex_src2;
                    mul_unsigned_d = op_is_unsigned(ex_op);
                    mul_valid_d    = 1'b1;
                    state_d        = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mul_if.mul_done) begin
                    p_d = mul_if.mul_result[2*DATA_W-1:0];
                    // A flush that coincides with mul_done has nothing left to drain.
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else if (acc_op) begin
                        state_d = ST_ACC;
                    end else begin
                        if (op_q == MUL_OP_MUL) begin
                            gpr_result_d = mul_if.mul_result[DATA_W-1:0];
                        end else begin
                            hi_out_d = mul_if.mul_result[2*DATA_W-1:DATA_W];
                            lo_out_d = mul_if.mul_result[DATA_W-1:0];
                        end
                        state_d = ST_DONE;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_ACC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_out_d = acc_res[2*DATA_W-1:DATA_W];
                    lo_out_d = acc_res[DATA_W-1:0];
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (mul_if.mul_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            op_q           <= '0;
            hi_l_q         <= '0;
            lo_l_q         <= '0;
            p_q            <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            mul_unsigned_q <= 1'b0;
            mul_valid_q    <= 1'b0;
            hi_out_q       <= '0;
            lo_out_q       <= '0;
            gpr_result_q   <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            hi_l_q         <= hi_l_d;
            lo_l_q         <= lo_l_d;
            p_q            <= p_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            mul_unsigned_q <= mul_unsigned_d;
            mul_valid_q    <= mul_valid_d;
            hi_out_q       <= hi_out_d;
            lo_out_q       <= lo_out_d;
            gpr_result_q   <= gpr_result_d;
        end
    end

    // Strobes are decoded from DONE so a flush arriving in that very cycle can still kill them.
    assign hilo_we   = (state_q == ST_DONE) && !flush && (op_q != MUL_OP_MUL);
    assign gpr_valid = (state_q == ST_DONE) && !flush && (op_q == MUL_OP_MUL);
    assign stall_req = ((state_q == ST_IDLE) && issue) || (state_q == ST_WAIT) ||
                       (state_q == ST_ACC) || ((state_q == ST_DRAIN) && ex_op_valid);

    assign hi_out              = hi_out_q;
    assign lo_out              = lo_out_q;
    assign gpr_result          = gpr_result_q;
    assign mul_if.mul_valid    = mul_valid_q;
    assign mul_if.mul_a        = mul_a_q;
    assign mul_if.mul_b        = mul_b_q;
    assign mul_if.mul_unsigned = mul_unsigned_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: behavioural mul unit with variable latency, spec-level result model, scenario tasks.
module tb_mul_ctrl;
    import mul_ctrl_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         ex_op_valid;
    logic [2:0]   ex_op;
    logic [W-1:0] ex_src1, ex_src2, hi_in, lo_in;
    logic         flush;
    logic         stall_req, hilo_we, gpr_valid;
    logic [W-1:0] hi_out, lo_out, gpr_result;
    mul_state_e   dbg_state;

    int checks = 0;
    int errors = 0;
    logic [2*W:0] exp_q[$];

    always #5 clk = ~clk;

    mul_ctrl_if #(.DATA_W(W)) mif ();

    mul_ctrl #(.DATA_W(W), .ACC_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .ex_op_valid(ex_op_valid), .ex_op(ex_op),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .hi_in(hi_in), .lo_in(lo_in), .flush(flush),
        .stall_req(stall_req), .hilo_we(hilo_we), .hi_out(hi_out), .lo_out(lo_out),
        .gpr_valid(gpr_valid), .gpr_result(gpr_result), .mul_if(mif), .dbg_state(dbg_state)
    );

    // Behavioural mul unit: mul_done arrives mul_lat cycles after the mul_valid cycle.
    int unsigned    mul_lat = 2;
    int unsigned    m_cnt = 0;
    logic [2*W+1:0] m_res = '0;

    function automatic logic [2*W-1:0] unit_product(input logic [W-1:0] a, b, input logic u);
        longint sa, sb;
        if (u) return {{W{1'b0}}, a} * {{W{1'b0}}, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return sa * sb;
    endfunction

    always @(posedge clk) begin
        if (mif.mul_valid === 1'b1) begin
            m_cnt <= mul_lat;
            m_res <= {2'($urandom_range(0, 3)), unit_product(mif.mul_a, mif.mul_b, mif.mul_unsigned)};
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign mif.mul_done   = (m_cnt == 1);
    assign mif.mul_result = m_res;

    int           mv_cnt = 0;
    logic [W-1:0] cap_a, cap_b;
    logic         cap_u;
    always @(posedge clk) begin
        if (mif.mul_valid === 1'b1) begin
            mv_cnt++;
            cap_a = mif.mul_a;
            cap_b = mif.mul_b;
            cap_u = mif.mul_unsigned;
        end
    end

    // Reference: {is_gpr, 64-bit value} straight from the instruction semantics.
    function automatic logic [2*W:0] ref_model(input logic [2:0] op, input logic [W-1:0] a, b, h, l);
        logic [63:0] p, acc;
        longint      sa, sb;
        if (op == 3'd1 || op == 3'd3 || op == 3'd5) begin
            p = {32'b0, a} * {32'b0, b};
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = sa * sb;
        end
        acc = {h, l};
        case (op)
            3'd2, 3'd3: return {1'b0, acc + p};
            3'd4, 3'd5: return {1'b0, acc - p};
            3'd6:       return {1'b1, 32'b0, p[31:0]};
            default:    return {1'b0, p};
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ex_op_valid = 1'b0;
            flush = 1'b0;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b, h, l);
        logic [2*W:0] exp_e;
        int           exp_lat, cyc, mv0;
        bit           seen, stall_bad;
        exp_q.push_back(ref_model(op, a, b, h, l));
        exp_lat = int'(mul_lat) + 2 + ((op >= 3'd2 && op <= 3'd5) ? 1 : 0);
        mv0 = mv_cnt;
        @(negedge clk);
        ex_op_valid = 1'b1; ex_op = op; ex_src1 = a; ex_src2 = b; hi_in = h; lo_in = l; flush = 1'b0;
        #1;
        checks++;
        if (stall_req !== 1'b1 || hilo_we !== 1'b0 || gpr_valid !== 1'b0) begin
            errors++;
            $display("FAIL issue_cycle op=%0d: stall/hilo_we/gpr_valid=%b%b%b, required 100",
                     op, stall_req, hilo_we, gpr_valid);
        end
        seen = 0; stall_bad = 0; cyc = 0;
        while (!seen && cyc < exp_lat + 20) begin
            @(negedge clk);
            cyc++;
            ex_src1 = $urandom(); ex_src2 = $urandom(); hi_in = $urandom(); lo_in = $urandom();
            #1;
            if (hilo_we === 1'b1 || gpr_valid === 1'b1) seen = 1;
            else if (stall_req !== 1'b1) stall_bad = 1;
        end
        exp_e = exp_q.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL strobe_timeout op=%0d: no strobe after %0d cycles, required one", op, cyc);
        end else begin
            checks++;
            if (cyc != exp_lat) begin
                errors++;
                $display("FAIL latency op=%0d: got %0d cycles, required %0d", op, cyc, exp_lat);
            end
            checks++;
            if (gpr_valid !== exp_e[2*W] || hilo_we !== !exp_e[2*W]) begin
                errors++;
                $display("FAIL strobe_kind op=%0d: gpr_valid=%b hilo_we=%b, required gpr_valid=%b",
                         op, gpr_valid, hilo_we, exp_e[2*W]);
            end
            checks++;
            if (exp_e[2*W]) begin
                if (gpr_result !== exp_e[W-1:0]) begin
                    errors++;
                    $display("FAIL gpr_result op=%0d a=%h b=%h: got %h, required %h",
                             op, a, b, gpr_result, exp_e[W-1:0]);
                end
            end else if ({hi_out, lo_out} !== exp_e[2*W-1:0]) begin
                errors++;
                $display("FAIL hilo_data op=%0d a=%h b=%h hi=%h lo=%h: got %h_%h, required %h",
                         op, a, b, h, l, hi_out, lo_out, exp_e[2*W-1:0]);
            end
            checks++;
            if (stall_req !== 1'b0) begin
                errors++;
                $display("FAIL done_stall op=%0d: got %b, required 0", op, stall_req);
            end
        end
        checks++;
        if (stall_bad) begin
            errors++;
            $display("FAIL stall_hold op=%0d: stall_req dropped before the strobe, required held", op);
        end
        checks++;
        if (mv_cnt - mv0 != 1 || cap_a !== a || cap_b !== b ||
            cap_u !== (op == 3'd1 || op == 3'd3 || op == 3'd5)) begin
            errors++;
            $display("FAIL mul_request op=%0d: pulses=%0d a=%h b=%h u=%b, required 1 %h %h %b",
                     op, mv_cnt - mv0, cap_a, cap_b, cap_u, a, b,
                     (op == 3'd1 || op == 3'd3 || op == 3'd5));
        end
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if ({stall_req, hilo_we, gpr_valid, mif.mul_valid, mif.mul_unsigned} !== 5'b0 ||
            {hi_out, lo_out, gpr_result, mif.mul_a, mif.mul_b} !== '0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL %s: ctl=%b%b%b%b%b hi=%h lo=%h gpr=%h a=%h b=%h state=%0d, required all 0 and IDLE",
                     name, stall_req, hilo_we, gpr_valid, mif.mul_valid, mif.mul_unsigned,
                     hi_out, lo_out, gpr_result, mif.mul_a, mif.mul_b, dbg_state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; ex_op_valid = 1'b0; ex_op = '0; flush = 1'b0;
        ex_src1 = '0; ex_src2 = '0; hi_in = '0; lo_in = '0;
        repeat (3) @(negedge clk);
        #1;
        check_cleared("reset_state");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_cleared("after_reset_release");
    endtask

    task automatic check_lo(input string name, input logic [W-1:0] hi_e, lo_e);
        checks++;
        if (hi_out !== hi_e || lo_out !== lo_e) begin
            errors++;
            $display("FAIL %s: got hi=%h lo=%h, required hi=%h lo=%h", name, hi_out, lo_out, hi_e, lo_e);
        end
    endtask

    task automatic test_directed();
        mul_lat = 3;
        run_op(MUL_OP_MULTU, 32'd10, 32'd20, 32'd0, 32'd0);
        check_lo("multu_10x20", 32'h0, 32'h0000_00C8);
        run_op(MUL_OP_MULT, -32'sd888, 32'sd666, 32'd0, 32'd0);
        run_op(MUL_OP_MUL, -32'sd888, 32'sd666, 32'd0, 32'd0);
        run_op(MUL_OP_MADD, 32'd10, 32'd20, 32'd0, 32'd100);
        check_lo("madd_10x20_plus100", 32'h0, 32'h0000_012C);
        run_op(MUL_OP_MSUBU, 32'd1, 32'd1, 32'd0, 32'd0);
        check_lo("msubu_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(2);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            mul_lat = $urandom_range(1, 5);
            run_op(3'($urandom_range(0, 6)), pick(), pick(), pick(), pick());
        end
        idle(2);
    endtask

    task automatic run_flush(input logic [2:0] op, input int flush_at, flush_len, input string name);
        int mv0, strobes;
        mv0 = mv_cnt; strobes = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            ex_op_valid = (c < flush_at + flush_len);
            ex_op = op; ex_src1 = $urandom(); ex_src2 = $urandom(); hi_in = $urandom(); lo_in = $urandom();
            flush = (c >= flush_at) && (c < flush_at + flush_len);
            #1;
            if (hilo_we === 1'b1 || gpr_valid === 1'b1) strobes++;
            if (c == 0) begin
                checks++;
                if (stall_req !== (flush_at != 0)) begin
                    errors++;
                    $display("FAIL %s_issue_stall: got %b, required %b", name, stall_req, flush_at != 0);
                end
            end
        end
        checks++;
        if (strobes != 0 || mv_cnt - mv0 != ((flush_at == 0) ? 0 : 1) ||
            dbg_state !== ST_IDLE || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL %s: strobes=%0d pulses=%0d state=%0d stall=%b, required 0 %0d IDLE 0",
                     name, strobes, mv_cnt - mv0, dbg_state, stall_req, (flush_at == 0) ? 0 : 1);
        end
    endtask

    task automatic test_flush_cases();
        mul_lat = 3;
        run_flush(MUL_OP_MULT, 0, 2, "flush_idle");
        run_flush(MUL_OP_MULT, 2, 1, "flush_wait");
        mul_lat = 5;
        run_flush(MUL_OP_MULTU, 2, 4, "flush_into_drain");
        mul_lat = 2;
        run_flush(MUL_OP_MADD, 4, 1, "flush_acc");
        run_flush(MUL_OP_MULT, 4, 1, "flush_done_hilo");
        run_flush(MUL_OP_MUL, 4, 1, "flush_done_gpr");
        run_op(MUL_OP_MSUB, pick(), pick(), pick(), pick());
        idle(2);
    endtask

    task automatic test_flush_drain_next();
        int  mv0, cyc;
        bit  seen, stall_bad, early;
        logic [2*W:0] exp_e;
        mul_lat = 4; mv0 = mv_cnt;
        exp_q.push_back(ref_model(MUL_OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd0));
        @(negedge clk);
        ex_op_valid = 1'b1; ex_op = MUL_OP_MULT; ex_src1 = -32'sd777700; ex_src2 = -32'sd666600;
        hi_in = '0; lo_in = '0; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1; ex_op = MUL_OP_MULTU; ex_src1 = 32'd3; ex_src2 = 32'd4;
        #1;
        early = (hilo_we === 1'b1 || gpr_valid === 1'b1);
        @(negedge clk);
        flush = 1'b0;
        seen = 0; stall_bad = 0; cyc = 0;
        while (!seen && cyc < 40) begin
            #1;
            if (hilo_we === 1'b1 || gpr_valid === 1'b1) seen = 1;
            else begin
                if (stall_req !== 1'b1) stall_bad = 1;
                @(negedge clk);
                cyc++;
            end
        end
        exp_e = exp_q.pop_front();
        checks++;
        if (!seen || early || hilo_we !== 1'b1 || {hi_out, lo_out} !== exp_e[2*W-1:0]) begin
            errors++;
            $display("FAIL drain_then_next: seen=%b early=%b hilo_we=%b got %h_%h, required %h",
                     seen, early, hilo_we, hi_out, lo_out, exp_e[2*W-1:0]);
        end
        checks++;
        if (stall_bad || mv_cnt - mv0 != 2) begin
            errors++;
            $display("FAIL drain_stall_pulses: stall_gap=%b pulses=%0d, required 0 and 2",
                     stall_bad, mv_cnt - mv0);
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        int mv0, strobes;
        mul_lat = 5; mv0 = mv_cnt; strobes = 0;
        @(negedge clk);
        ex_op_valid = 1'b1; ex_op = MUL_OP_MULTU; ex_src1 = $urandom(); ex_src2 = $urandom(); flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; ex_op_valid = 1'b0;
        @(negedge clk);
        #1;
        check_cleared("reset_mid_op");
        reset = 1'b1;
        for (int c = 0; c < 20 && m_cnt != 0; c++) begin
            @(negedge clk);
            #1;
            if (hilo_we === 1'b1 || gpr_valid === 1'b1) strobes++;
        end
        idle(2);
        checks++;
        if (strobes != 0 || m_cnt != 0 || dbg_state !== ST_IDLE || mv_cnt - mv0 != 1) begin
            errors++;
            $display("FAIL stale_done: strobes=%0d busy=%0d state=%0d pulses=%0d, required 0 0 IDLE 1",
                     strobes, m_cnt, dbg_state, mv_cnt - mv0);
        end
        mul_lat = 2;
        run_op(MUL_OP_MULTU, 32'd2, 32'd2, 32'd0, 32'd0);
        check_lo("after_reset_2x2", 32'h0, 32'd4);
        idle(2);
    endtask

    task automatic test_reserved();
        int mv0;
        bit bad;
        mv0 = mv_cnt; bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ex_op_valid = 1'b1; ex_op = MUL_OP_RSVD; ex_src1 = $urandom(); ex_src2 = $urandom();
            #1;
            if (stall_req !== 1'b0) bad = 1;
        end
        idle(2);
        checks++;
        if (bad || mv_cnt - mv0 != 0) begin
            errors++;
            $display("FAIL reserved_op: stalled=%b pulses=%0d, required 0 0", bad, mv_cnt - mv0);
        end
    endtask

    task automatic test_back_to_back();
        int mv0;
        mul_lat = 2; mv0 = mv_cnt;
        run_op(MUL_OP_MULTU, 32'd5, 32'd5, 32'd0, 32'd0);
        check_lo("b2b_first", 32'h0, 32'd25);
        run_op(MUL_OP_MULTU, 32'd6, 32'd6, 32'd0, 32'd0);
        check_lo("b2b_second", 32'h0, 32'd36);
        checks++;
        if (mv_cnt - mv0 != 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d, required 2", mv_cnt - mv0);
        end
        idle(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reserved();
        test_flush_cases();
        test_flush_drain_next();
        test_reset_mid();
        test_random();
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
